// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program-counter unit: FSM states,
// next-PC source encoding and the fixed instruction size.
package pc_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DONE  = 2'd1,
      FAULT = 2'd2
   } pc_state_e;

   typedef enum logic [1:0] {
      SEQ  = 2'd0,
      BR   = 2'd1,
      JAL  = 2'd2,
      JALR = 2'd3
   } pc_src_e;

   localparam int INST_BYTES = 4;

   // A transfer target must be word aligned and land inside program memory.
   function automatic logic target_ok(input logic [1:0] lsb, input logic in_range);
      return (lsb == 2'b00) && in_range;
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC source selection: priority jalr > jump > taken branch > sequential,
// target adders and the alignment/range checks for the selected source.
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] PC_LIMIT = 'h200,
   parameter int              BR_SHIFT = 1
) (
   input  logic [PC_W-1:0] pc,
   input  logic            branch,
   input  logic            alu_zero,
   input  logic            br_invert,
   input  logic            jump,
   input  logic            jalr,
   input  logic [XLEN-1:0] offset,
   input  logic [XLEN-1:0] jalr_base,
   output logic [PC_W-1:0] next_pc,
   output logic            target_valid,
   output logic            seq_valid,
   output pc_src_e         src_sel
);

   logic [XLEN-1:0] br_off;
   logic [XLEN-1:0] jalr_sum;
   logic [PC_W-1:0] rel_target;
   logic [PC_W-1:0] jalr_target;
   logic [PC_W-1:0] seq_pc;
   logic [PC_W:0]   seq_wide;
   logic            br_taken;

   assign br_off      = offset << BR_SHIFT;
   assign jalr_sum    = jalr_base + offset;
   // All sums are taken modulo 2^PC_W before any checking.
   assign rel_target  = pc + br_off[PC_W-1:0];
   assign jalr_target = {jalr_sum[PC_W-1:1], 1'b0};
   assign seq_pc      = pc + PC_W'(INST_BYTES);
   // Extra bit so a PC near the top of the address space cannot wrap below the limit.
   assign seq_wide    = {1'b0, pc} + (PC_W+1)'(INST_BYTES);
   assign seq_valid   = seq_wide < {1'b0, PC_LIMIT};
   assign br_taken    = branch & (alu_zero ^ br_invert);

   always_comb begin
      src_sel      = SEQ;
      next_pc      = seq_pc;
      target_valid = 1'b0;
      if (jalr) begin
         src_sel = JALR;
         next_pc = jalr_target;
      end else if (jump) begin
         src_sel = JAL;
         next_pc = rel_target;
      end else if (br_taken) begin
         src_sel = BR;
         next_pc = rel_target;
      end
      if (src_sel != SEQ) begin
         target_valid = target_ok(next_pc[1:0], next_pc < PC_LIMIT);
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: PC register, RUN/DONE/FAULT state machine and
// a saturating count of accepted PC updates.
module pc_unit
   import pc_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] PC_LIMIT = 'h200,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              BR_SHIFT = 1,
   parameter int              COUNT_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pc_write,
   input  logic               branch,
   input  logic               alu_zero,
   input  logic               br_invert,
   input  logic               jump,
   input  logic               jalr,
   input  logic [XLEN-1:0]    offset,
   input  logic [XLEN-1:0]    jalr_base,
   output logic [PC_W-1:0]    pc_out,
   output logic [PC_W-1:0]    pc_link,
   output logic               redirect,
   output logic               done,
   output logic               fault,
   output logic [COUNT_W-1:0] inst_count
);

   pc_state_e          state_reg, state_next;
   logic [PC_W-1:0]    pc_reg, pc_next;
   logic [COUNT_W-1:0] count_reg, count_next;

   logic [PC_W-1:0]    sel_pc;
   logic               target_valid;
   logic               seq_valid;
   pc_src_e            src_sel;
   logic               accept;

   pc_next_sel #(
      .XLEN     (XLEN),
      .PC_W     (PC_W),
      .PC_LIMIT (PC_LIMIT),
      .BR_SHIFT (BR_SHIFT)
   ) u_next_sel (
      .pc           (pc_reg),
      .branch       (branch),
      .alu_zero     (alu_zero),
      .br_invert    (br_invert),
      .jump         (jump),
      .jalr         (jalr),
      .offset       (offset),
      .jalr_base    (jalr_base),
      .next_pc      (sel_pc),
      .target_valid (target_valid),
      .seq_valid    (seq_valid),
      .src_sel      (src_sel)
   );

   assign accept = (state_reg == RUN) && pc_write;

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      count_next = count_reg;
      if (accept) begin
         if (src_sel != SEQ) begin
            if (target_valid) begin
               pc_next = sel_pc;
            end else begin
               state_next = FAULT;
            end
         end else if (seq_valid) begin
            pc_next = sel_pc;
         end else begin
            // Stepping past the last instruction slot ends the program.
            state_next = DONE;
         end
         if (state_next == RUN && count_reg != '1) begin
            count_next = count_reg + COUNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RUN;
         pc_reg    <= RESET_PC;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         count_reg <= count_next;
      end
   end

   assign pc_out     = pc_reg;
   assign pc_link    = pc_reg + PC_W'(INST_BYTES);
   assign redirect   = accept && (src_sel != SEQ) && target_valid;
   assign done       = (state_reg == DONE);
   assign fault      = (state_reg == FAULT);
   assign inst_count = count_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random stimulus,
// all compared against an arithmetic reference model of the PC rules.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_write = 1'b0;
   logic        branch = 1'b0;
   logic        alu_zero = 1'b0;
   logic        br_invert = 1'b0;
   logic        jump = 1'b0;
   logic        jalr = 1'b0;
   logic [63:0] offset = '0;
   logic [63:0] jalr_base = '0;
   logic [31:0] pc_out;
   logic [31:0] pc_link;
   logic        redirect;
   logic        done;
   logic        fault;
   logic [31:0] inst_count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: 0 = running, 1 = completed, 2 = faulted.
   longint unsigned m_pc  = 0;
   longint unsigned m_cnt = 0;
   int              m_st  = 0;

   localparam longint unsigned LIMIT = 64'h200;
   localparam longint unsigned MASK  = 64'hFFFF_FFFF;

   pc_unit dut (
      .clk        (clk),
      .rst        (rst),
      .pc_write   (pc_write),
      .branch     (branch),
      .alu_zero   (alu_zero),
      .br_invert  (br_invert),
      .jump       (jump),
      .jalr       (jalr),
      .offset     (offset),
      .jalr_base  (jalr_base),
      .pc_out     (pc_out),
      .pc_link    (pc_link),
      .redirect   (redirect),
      .done       (done),
      .fault      (fault),
      .inst_count (inst_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock of stimulus: checks the combinational outputs before the edge
   // and the registered state after it.
   task automatic step(input bit r, input bit pw, input bit br, input bit z, input bit inv,
                       input bit j, input bit jr, input logic [63:0] off, input logic [63:0] base);
      bit              taken;
      bit              ok;
      bit              exp_red;
      longint unsigned tgt;
      @(negedge clk);
      rst = r; pc_write = pw; branch = br; alu_zero = z; br_invert = inv;
      jump = j; jalr = jr; offset = off; jalr_base = base;
      taken = 1'b1;
      tgt   = 0;
      if (jr)
         tgt = ((base + off) & MASK) & ~64'd1;
      else if (j || (br && (z != inv)))
         tgt = (m_pc + (off << 1)) & MASK;
      else
         taken = 1'b0;
      ok      = (tgt % 4 == 0) && (tgt < LIMIT);
      exp_red = (m_st == 0) && pw && taken && ok;
      #1;
      check_eq("pc_link", pc_link, (m_pc + 4) & MASK);
      check_eq("redirect", redirect, exp_red);
      @(posedge clk);
      #1;
      if (r) begin
         m_pc = 0; m_cnt = 0; m_st = 0;
      end else if (m_st == 0 && pw) begin
         if (taken) begin
            if (ok) begin m_pc = tgt; m_cnt++; end
            else m_st = 2;
         end else if (m_pc + 4 < LIMIT) begin
            m_pc = m_pc + 4; m_cnt++;
         end else begin
            m_st = 1;
         end
      end
      $display("step r=%0b pw=%0b br=%0b z=%0b inv=%0b j=%0b jr=%0b off=%0h base=%0h -> pc=%0h cnt=%0d done=%0b fault=%0b",
               r, pw, br, z, inv, j, jr, off, base, pc_out, inst_count, done, fault);
      check_eq("pc_out", pc_out, m_pc);
      check_eq("inst_count", inst_count, m_cnt);
      check_eq("done", done, m_st == 1);
      check_eq("fault", fault, m_st == 2);
   endtask

   task automatic seq_step();
      step(0, 1, 0, 0, 0, 0, 0, 64'd0, 64'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_pc", pc_out, 32'h0);
      check_eq("reset_link", pc_link, 32'h4);
      check_eq("reset_done", done, 1'b0);
      check_eq("reset_fault", fault, 1'b0);
      check_eq("reset_count", inst_count, 32'h0);
      check_eq("reset_redirect", redirect, 1'b0);

      // Five sequential steps from reset.
      step(0, 1, 0, 0, 0, 0, 0, 64'd0, 64'd0);
      repeat (4) seq_step();
      check_eq("seq5_pc", pc_out, 32'h14);
      check_eq("seq5_count", inst_count, 32'd5);

      // Stall at 8.
      step(1, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
      repeat (2) seq_step();
      repeat (3) step(0, 0, 0, 0, 0, 1, 0, 64'd8, 64'd0);
      check_eq("stall_pc", pc_out, 32'h8);
      seq_step();
      check_eq("unstall_pc", pc_out, 32'hC);

      // BEQ taken / not taken, BNE taken, from 0x10.
      seq_step();
      step(0, 1, 1, 1, 0, 0, 0, 64'd8, 64'd0);
      check_eq("beq_pc", pc_out, 32'h20);
      step(0, 1, 0, 0, 0, 0, 1, 64'd0, 64'h10);
      step(0, 1, 1, 0, 0, 0, 0, 64'd8, 64'd0);
      check_eq("beq_nt_pc", pc_out, 32'h14);
      step(0, 1, 0, 0, 0, 0, 1, 64'd0, 64'h10);
      step(0, 1, 1, 0, 1, 0, 0, 64'd8, 64'd0);
      check_eq("bne_pc", pc_out, 32'h20);

      // Priority and JALR, then a misaligned JALR target.
      step(0, 1, 1, 1, 0, 1, 1, 64'd0, 64'h41);
      check_eq("jalr_pri_pc", pc_out, 32'h40);
      step(0, 1, 0, 0, 0, 0, 1, 64'd0, 64'h42);
      check_eq("jalr_fault", fault, 1'b1);
      step(0, 1, 0, 0, 0, 1, 0, 64'd4, 64'd0);
      check_eq("fault_hold_pc", pc_out, 32'h40);

      // Program limit.
      step(1, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
      step(0, 1, 0, 0, 0, 0, 1, 64'd0, 64'h1F8);
      seq_step();
      seq_step();
      check_eq("limit_done", done, 1'b1);
      check_eq("limit_pc", pc_out, 32'h1FC);
      step(0, 1, 0, 0, 0, 1, 0, 64'h10, 64'd0);
      step(1, 1, 0, 0, 0, 0, 0, 64'd0, 64'd0);
      check_eq("limit_rst_pc", pc_out, 32'h0);
      check_eq("limit_rst_done", done, 1'b0);

      // Out-of-range branch target.
      step(0, 1, 0, 0, 0, 0, 1, 64'd0, 64'h1F0);
      step(0, 1, 1, 1, 0, 0, 0, 64'h10, 64'd0);
      check_eq("range_fault", fault, 1'b1);
      check_eq("range_pc", pc_out, 32'h1F0);

      // Wrap-around: 0x20 + (-0x10 << 1) wraps to 0 mod 2^32.
      step(1, 0, 0, 0, 0, 0, 0, 64'd0, 64'd0);
      step(0, 1, 0, 0, 0, 0, 1, 64'd0, 64'h20);
      step(0, 1, 0, 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0);
      check_eq("wrap_pc", pc_out, 32'h0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit          r;
         logic [63:0] off;
         logic [63:0] base;
         r = ($urandom_range(0, 39) == 0) || (m_st != 0 && $urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0)
            off = {$urandom, $urandom};
         else
            off = 64'(longint'($urandom_range(0, 40)) - 64'sd20);
         base = 64'($urandom_range(0, 'h220));
         step(r, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, 1'($urandom),
              1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, off, base);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
